multi_priority_arbiter: RTL and testbench

Parametrised, registered successor to the 12-bit two-result priority encoder. Each accepted request vector returns the K highest-priority asserted indices, in either fixed or round-robin mode. Results sit behind a valid/ready output register. It is used as a grant stage between request collectors and shared-resource schedulers in the prototyping designs.

---
 rtl/multi_priority_arbiter_pkg.sv | 4 +
 rtl/multi_priority_arbiter_if.sv | 22 ++
 rtl/multi_priority_arbiter_priority_pick.sv | 26 ++
 rtl/multi_priority_arbiter.sv | 62 ++++++
 tb/tb_multi_priority_arbiter.sv | 123 ++++++++++++
 5 files changed

// File: rtl/multi_priority_arbiter_pkg.sv
// multi_prio_pkg: shared types for the multi-grant priority arbiter.
package multi_prio_pkg;
    typedef enum logic {PRIO_FIXED = 1'b0, PRIO_RR = 1'b1} prio_mode_t;
endpackage

// File: rtl/multi_priority_arbiter_if.sv
// multi_priority_arbiter_if: request/result handshake bundle for the arbiter.
interface multi_priority_arbiter_if #(
    parameter int N = 12,
    parameter int K = 2,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(K + 1)
) ();
    import multi_prio_pkg::*;
    prio_mode_t                  mode;
    logic                        in_valid;
    logic                        in_ready;
    logic [N-1:0]                req;
    logic                        out_valid;
    logic                        out_ready;
    logic [K-1:0][IDX_W-1:0]     idx;
    logic [K-1:0]                hit;
    logic [CNT_W-1:0]            count;
    modport master (output mode, in_valid, req, out_ready,
                    input in_ready, out_valid, idx, hit, count);
    modport slave (input mode, in_valid, req, out_ready,
                   output in_ready, out_valid, idx, hit, count);
endinterface

// File: rtl/multi_priority_arbiter_priority_pick.sv
// priority_pick: finds the first set bit scanning downward from start, wrapping N-1 after 0.
module priority_pick #(
    parameter int N = 12,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic [N-1:0]     onehot
);
    // Scan lowest priority first so the highest-priority hit is the last write.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = (int'(start) >= i) ? int'(start) - i : int'(start) + N - i;
            if (vec[j]) begin
                found = 1'b1;
                index = IDX_W'(j);
            end
        end
    end
    assign onehot = found ? (N'(1) << index) : '0;
endmodule

// File: rtl/multi_priority_arbiter.sv
// multi_priority_arbiter: registered K-grant picker with fixed or round-robin priority.
module multi_priority_arbiter
    import multi_prio_pkg::*;
#(
    parameter int N = 12,
    parameter int K = 2,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(K + 1)
) (
    input logic clk,
    input logic reset,
    multi_priority_arbiter_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        start;
    logic [K:0][N-1:0]       rem;
    logic [K-1:0][N-1:0]     oh;
    logic [K-1:0][IDX_W-1:0] pick_idx;
    logic [K-1:0]            found;
    logic [CNT_W-1:0]        cnt_n;
    logic [IDX_W-1:0]        last_idx;
    logic                    accept;
    assign start     = (bus.mode == PRIO_RR) ? ptr : LAST;
    assign rem[0]    = bus.req;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept    = bus.in_valid && bus.in_ready;
    for (genvar k = 0; k < K; k++) begin : g_stage
        priority_pick #(.N(N)) u_pick (
            .vec(rem[k]), .start(start),
            .found(found[k]), .index(pick_idx[k]), .onehot(oh[k])
        );
        assign rem[k+1] = rem[k] & ~oh[k];
    end
    // Slots fill in order, so the last found slot is the lowest-priority grant.
    always_comb begin
        cnt_n = '0;
        last_idx = '0;
        for (int k = 0; k < K; k++) begin
            cnt_n = cnt_n + CNT_W'(found[k]);
            if (found[k]) last_idx = pick_idx[k];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.idx <= '0;
            bus.hit <= '0;
            bus.count <= '0;
            ptr <= LAST;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.idx <= pick_idx;
            bus.hit <= found;
            bus.count <= cnt_n;
            if (bus.mode == PRIO_RR && cnt_n != '0)
                ptr <= (last_idx == '0) ? LAST : last_idx - 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_priority_arbiter.sv
// tb_multi_priority_arbiter: directed checks on N=12/K=2 and N=5/K=3 instances.
module tb_multi_priority_arbiter;
    import multi_prio_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    multi_priority_arbiter_if #(.N(12), .K(2)) a ();
    multi_priority_arbiter_if #(.N(5), .K(3)) b ();
    multi_priority_arbiter #(.N(12), .K(2)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    multi_priority_arbiter #(.N(5), .K(3)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        a.mode = PRIO_FIXED; a.in_valid = 1'b0; a.req = '0; a.out_ready = 1'b1;
        b.mode = PRIO_FIXED; b.in_valid = 1'b0; b.req = '0; b.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", a.out_valid, 0);
        check("rst_hit", a.hit, 0);
        check("rst_count", a.count, 0);
        check("rst_ptr", dut_a.ptr, 11);
        a.req = 12'hA40; a.in_valid = 1'b1;
        #1 check("t1_in_ready", a.in_ready, 1);
        step();
        check("t1_valid", a.out_valid, 1);
        check("t1_idx0", a.idx[0], 11);
        check("t1_idx1", a.idx[1], 9);
        check("t1_hit", a.hit, 2'b11);
        check("t1_count", a.count, 2);
        a.req = 12'h001;
        step();
        check("t2_idx0", a.idx[0], 0);
        check("t2_hit", a.hit, 2'b01);
        check("t2_count", a.count, 1);
        a.req = 12'h000;
        step();
        check("t2z_valid", a.out_valid, 1);
        check("t2z_hit", a.hit, 0);
        check("t2z_count", a.count, 0);
        a.in_valid = 1'b0;
        step();
        check("drain_valid", a.out_valid, 0);
        a.mode = PRIO_RR; a.req = 12'hFFF; a.in_valid = 1'b1;
        step();
        check("rr1_idx0", a.idx[0], 11);
        check("rr1_idx1", a.idx[1], 10);
        check("rr1_ptr", dut_a.ptr, 9);
        step();
        check("rr2_idx0", a.idx[0], 9);
        check("rr2_idx1", a.idx[1], 8);
        check("rr2_ptr", dut_a.ptr, 7);
        a.req = 12'h003;
        step();
        check("rr3_idx0", a.idx[0], 1);
        check("rr3_idx1", a.idx[1], 0);
        check("rr3_ptr", dut_a.ptr, 11);
        a.out_ready = 1'b0; a.req = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", a.in_ready, 0);
            step();
            check("bp_valid", a.out_valid, 1);
            check("bp_idx0", a.idx[0], 1);
            check("bp_idx1", a.idx[1], 0);
            check("bp_ptr", dut_a.ptr, 11);
        end
        a.out_ready = 1'b1;
        #1 check("bp_release_ready", a.in_ready, 1);
        step();
        check("bp_new_idx0", a.idx[0], 11);
        check("bp_new_idx1", a.idx[1], 10);
        check("bp_new_ptr", dut_a.ptr, 9);
        a.in_valid = 1'b0; a.out_ready = 1'b0;
        step();
        check("t5_pending", a.out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_valid", a.out_valid, 0);
        check("t5_hit", a.hit, 0);
        check("t5_count", a.count, 0);
        check("t5_ptr", dut_a.ptr, 11);
        a.out_ready = 1'b1; a.in_valid = 1'b1; a.req = 12'hFFF;
        step();
        check("t5_idx0", a.idx[0], 11);
        check("t5_idx1", a.idx[1], 10);
        a.in_valid = 1'b0;
        b.req = 5'b10110; b.in_valid = 1'b1;
        step();
        check("b1_idx0", b.idx[0], 4);
        check("b1_idx1", b.idx[1], 2);
        check("b1_idx2", b.idx[2], 1);
        check("b1_hit", b.hit, 3'b111);
        check("b1_count", b.count, 3);
        b.req = 5'b11111;
        step();
        check("b2_idx0", b.idx[0], 4);
        check("b2_idx1", b.idx[1], 3);
        check("b2_idx2", b.idx[2], 2);
        check("b2_count", b.count, 3);
        b.req = 5'b00100;
        step();
        check("b3_idx0", b.idx[0], 2);
        check("b3_idx1", b.idx[1], 0);
        check("b3_hit", b.hit, 3'b001);
        check("b3_count", b.count, 1);
        b.in_valid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
